// File: rtl/vga_timing_gen_if.sv
// Pixel-stream bus shared by the video chain: position counters, sync, blanking, colour.
// Modport out drives the bus (timing source); modport in consumes it (overlay stages).
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (
    output hcount, vcount, hsync, vsync,
    output hblnk, vblnk, rgb
  );

  modport in (
    input hcount, vcount, hsync, vsync,
    input hblnk, vblnk, rgb
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing source: h/v counters, positive syncs, blanking, black rgb.
// Ports: clk, rst (sync, active-high), out (vga_if.out bus), frame_start (pulse at pixel 0,0).
module vga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   out,
  output logic frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_chk
    $fatal(1, "vga_timing_gen: total exceeds 2048");
  end

  if (H_VISIBLE <= 0 || H_FRONT <= 0 || H_SYNC <= 0 || H_BACK <= 0 ||
      V_VISIBLE <= 0 || V_FRONT <= 0 || V_SYNC <= 0 || V_BACK <= 0)
  begin : g_zero_chk
    $fatal(1, "vga_timing_gen: all timing parameters must be > 0");
  end

  if (H_VISIBLE + H_FRONT + H_SYNC >= H_TOTAL ||
      V_VISIBLE + V_FRONT + V_SYNC >= V_TOTAL) begin : g_sync_chk
    $fatal(1, "vga_timing_gen: sync outside blanking");
  end

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_ON  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_OFF = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_ON  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_OFF = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        h_wrap;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? 11'd0 : h_cnt + 11'd1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end
  end

  // Outputs decode the next counter values so every field in a
  // registered output cycle describes the same pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      out.hcount  <= '0;
      out.vcount  <= '0;
      out.hsync   <= 1'b0;
      out.vsync   <= 1'b0;
      out.hblnk   <= 1'b0;
      out.vblnk   <= 1'b0;
      out.rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      out.hcount  <= h_nxt;
      out.vcount  <= v_nxt;
      out.hsync   <= (h_nxt >= HS_ON) && (h_nxt < HS_OFF);
      out.vsync   <= (v_nxt >= VS_ON) && (v_nxt < VS_OFF);
      out.hblnk   <= (h_nxt >= H_VIS);
      out.vblnk   <= (v_nxt >= V_VIS);
      out.rgb     <= '0;
      frame_start <= (h_nxt == 11'd0) && (v_nxt == 11'd0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default 800x600 mode line checks
// plus a small 16x8 mode exercised over full frames and a mid-frame reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d;
  logic rst_s;
  logic fs_d;
  logic fs_s;

  vga_if vd();
  vga_if vs();

  vga_timing_gen dut_d (
    .clk(clk), .rst(rst_d), .out(vd), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .clk(clk), .rst(rst_s), .out(vs), .frame_start(fs_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input int n,
                         input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int cyc;
    int h;
    int v;
    int hs;
    int hb;
  } vec_t;

  vec_t tab[12];

  function automatic logic [39:0] pack_s();
    return {vs.hcount, vs.vcount, vs.hsync, vs.vsync,
            vs.hblnk, vs.vblnk, fs_s, vs.rgb, 1'b0};
  endfunction

  function automatic logic [39:0] model_s(input int n);
    int h;
    int v;
    logic hs, vsy, hb, vb, fs;
    h   = n % 16;
    v   = (n / 16) % 8;
    hs  = (h >= 10) && (h < 13);
    vsy = (v >= 5) && (v < 7);
    hb  = (h >= 8);
    vb  = (v >= 4);
    fs  = (h == 0) && (v == 0);
    return {11'(h), 11'(v), hs, vsy, hb, vb, fs, 12'h000, 1'b0};
  endfunction

  initial begin
    int k;
    int rise0, rise1, fall0, rise_h, fs_cnt;
    logic prev_hs;
    int last_fs, found;

    tab[0]  = '{1,    1,    0, 0, 0};
    tab[1]  = '{799,  799,  0, 0, 0};
    tab[2]  = '{800,  800,  0, 0, 1};
    tab[3]  = '{839,  839,  0, 0, 1};
    tab[4]  = '{840,  840,  0, 1, 1};
    tab[5]  = '{967,  967,  0, 1, 1};
    tab[6]  = '{968,  968,  0, 0, 1};
    tab[7]  = '{1055, 1055, 0, 0, 1};
    tab[8]  = '{1056, 0,    1, 0, 0};
    tab[9]  = '{1057, 1,    1, 0, 0};
    tab[10] = '{2111, 1055, 1, 0, 1};
    tab[11] = '{2952, 840,  2, 1, 1};

    rst_d = 1'b1;
    rst_s = 1'b1;
    repeat (3) tick();

    chk("d_rst_hcount", int'(vd.hcount), 0);
    chk("d_rst_vcount", int'(vd.vcount), 0);
    chk("d_rst_flags", int'({vd.hsync, vd.vsync, vd.hblnk, vd.vblnk, fs_d}), 0);
    chk("d_rst_rgb", int'(vd.rgb), 0);

    // Default mode: first lines after release.
    rst_d = 1'b0;
    k = 0;
    rise0 = -1; rise1 = -1; fall0 = -1; rise_h = -1; fs_cnt = 0;
    prev_hs = 1'b0;
    for (int n = 1; n <= 3300; n++) begin
      tick();
      if (fs_d) fs_cnt++;
      if (vd.hsync && !prev_hs) begin
        if (rise0 < 0) begin
          rise0 = n;
          rise_h = int'(vd.hcount);
        end else if (rise1 < 0) begin
          rise1 = n;
        end
      end
      if (!vd.hsync && prev_hs && fall0 < 0) fall0 = n;
      prev_hs = vd.hsync;
      if (k < 12 && n == tab[k].cyc) begin
        chk($sformatf("d_h@%0d", n), int'(vd.hcount), tab[k].h);
        chk($sformatf("d_v@%0d", n), int'(vd.vcount), tab[k].v);
        chk($sformatf("d_hs@%0d", n), int'(vd.hsync), tab[k].hs);
        chk($sformatf("d_hb@%0d", n), int'(vd.hblnk), tab[k].hb);
        chk($sformatf("d_vsvb@%0d", n), int'({vd.vsync, vd.vblnk}), 0);
        chk($sformatf("d_fs@%0d", n), int'(fs_d), 0);
        k++;
      end
    end
    chk("d_hsync_period", rise1 - rise0, 1056);
    chk("d_hsync_width", fall0 - rise0, 128);
    chk("d_hsync_start_h", rise_h, 840);
    chk("d_no_fs", fs_cnt, 0);
    rst_d = 1'b1;

    // Small mode: reset state, then scoreboard over three frames.
    chk_vec("s_rst", 0, pack_s(), 40'h0);
    rst_s = 1'b0;
    last_fs = 0;
    for (int n = 1; n <= 384; n++) begin
      tick();
      chk_vec("s_sb", n, pack_s(), model_s(n));
      if (fs_s) begin
        chk("s_fs_period", n - last_fs, 128);
        last_fs = n;
      end
    end

    // Wrap: last pixel of frame, then frame_start at (0,0).
    for (int n = 385; n <= 511; n++) tick();
    chk("s_wrap_pre_h", int'(vs.hcount), 15);
    chk("s_wrap_pre_v", int'(vs.vcount), 7);
    tick();
    chk("s_wrap_hv", int'({vs.hcount, vs.vcount}), 0);
    chk("s_wrap_blnk", int'({vs.hblnk, vs.vblnk}), 0);
    chk("s_wrap_fs", int'(fs_s), 1);

    // Mid-frame reset at (4,3).
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (vs.hcount == 11'd4 && vs.vcount == 11'd3) found = 1;
    end
    chk("s_find_mid", found, 1);
    rst_s = 1'b1;
    tick();
    chk_vec("s_mid_rst", 0, pack_s(), 40'h0);
    tick();
    rst_s = 1'b0;
    tick();
    chk("s_rel_h", int'(vs.hcount), 1);
    chk("s_rel_v", int'(vs.vcount), 0);
    chk("s_rel_fs", int'(fs_s), 0);
    fs_cnt = 0;
    for (int n = 2; n <= 127; n++) begin
      tick();
      if (fs_s) fs_cnt++;
    end
    chk("s_no_spurious_fs", fs_cnt, 0);
    tick();
    chk("s_first_fs", int'(fs_s), 1);
    chk("s_first_fs_hv", int'({vs.hcount, vs.vcount}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
